// File: rtl/query_result_handler.sv
// Snapshots per-window match counts, streams every window at or above THRESHOLD
// over valid/ready, and reports the best window, a match tally and a done strobe.
module query_result_handler #(
    parameter int NUM_WINDOWS = 16,
    parameter int ID_W        = 4,
    parameter int COUNT_W     = 8,
    parameter int THRESHOLD   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WINDOWS*COUNT_W-1:0] countBus,
    input  logic                           queryDone,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [ID_W-1:0]                outWindowID,
    output logic [COUNT_W-1:0]             outCount,
    output logic                           busy,
    output logic                           done,
    output logic                           bestValid,
    output logic [ID_W-1:0]                bestWindowID,
    output logic [COUNT_W-1:0]             bestCount,
    output logic [ID_W:0]                  numMatches
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ID_W-1:0]    LAST_IDX = ID_W'(NUM_WINDOWS - 1);
    localparam logic [COUNT_W-1:0] THRESH   = COUNT_W'(THRESHOLD);

    state_t               state_r;
    logic [COUNT_W-1:0]   snap_r [NUM_WINDOWS];
    logic [ID_W-1:0]      idx_r;

    logic [COUNT_W-1:0]   cur_count_s;
    logic                 is_cand_s;
    logic                 is_last_s;
    logic                 beats_best_s;

    // Strict greater-than keeps the lowest windowID among equal counts.
    function automatic logic improves_best(input logic [COUNT_W-1:0] cand,
                                           input logic [COUNT_W-1:0] best,
                                           input logic               have_best);
        return (!have_best) || (cand > best);
    endfunction

    // Decode the window currently addressed by the scan index.
    always_comb begin
        cur_count_s  = snap_r[idx_r];
        is_cand_s    = (cur_count_s >= THRESH);
        is_last_s    = (idx_r == LAST_IDX);
        beats_best_s = improves_best(cur_count_s, bestCount, bestValid);
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= {ID_W{1'b0}};
            outValid     <= 1'b0;
            outWindowID  <= {ID_W{1'b0}};
            outCount     <= {COUNT_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            bestValid    <= 1'b0;
            bestWindowID <= {ID_W{1'b0}};
            bestCount    <= {COUNT_W{1'b0}};
            numMatches   <= {(ID_W+1){1'b0}};
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                snap_r[i] <= {COUNT_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (queryDone) begin
                        for (int i = 0; i < NUM_WINDOWS; i++) begin
                            snap_r[i] <= countBus[i*COUNT_W +: COUNT_W];
                        end
                        idx_r        <= {ID_W{1'b0}};
                        bestValid    <= 1'b0;
                        bestWindowID <= {ID_W{1'b0}};
                        bestCount    <= {COUNT_W{1'b0}};
                        numMatches   <= {(ID_W+1){1'b0}};
                        busy         <= 1'b1;
                        state_r      <= SCAN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (is_cand_s) begin
                        outWindowID <= idx_r;
                        outCount    <= cur_count_s;
                        outValid    <= 1'b1;
                        numMatches  <= numMatches + (ID_W+1)'(1);
                        if (beats_best_s) begin
                            bestWindowID <= idx_r;
                            bestCount    <= cur_count_s;
                        end else begin
                            bestWindowID <= bestWindowID;
                            bestCount    <= bestCount;
                        end
                        bestValid <= 1'b1;
                        state_r   <= EMIT;
                    end else if (is_last_s) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + ID_W'(1);
                        state_r <= SCAN;
                    end
                end
                EMIT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        if (is_last_s) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r + ID_W'(1);
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    outValid <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_query_result_handler.sv
// Directed and randomized checks of query_result_handler against a
// list-based reference model of the candidate stream and scan results.
module tb_query_result_handler;

    localparam int NW = 16;
    localparam int IW = 4;
    localparam int CW = 8;
    localparam int TH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW*CW-1:0]  countBus;
    logic              queryDone;
    logic              outValid;
    logic              outReady;
    logic [IW-1:0]     outWindowID;
    logic [CW-1:0]     outCount;
    logic              busy;
    logic              done;
    logic              bestValid;
    logic [IW-1:0]     bestWindowID;
    logic [CW-1:0]     bestCount;
    logic [IW:0]       numMatches;

    int n_cmp = 0;
    int n_err = 0;
    int cnt [NW];

    query_result_handler #(
        .NUM_WINDOWS(NW), .ID_W(IW), .COUNT_W(CW), .THRESHOLD(TH)
    ) dut (
        .clk(clk), .reset(reset), .countBus(countBus), .queryDone(queryDone),
        .outValid(outValid), .outReady(outReady), .outWindowID(outWindowID),
        .outCount(outCount), .busy(busy), .done(done), .bestValid(bestValid),
        .bestWindowID(bestWindowID), .bestCount(bestCount), .numMatches(numMatches)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_bus_from_model();
        for (int i = 0; i < NW; i++) countBus[i*CW +: CW] = CW'(cnt[i]);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NW; i++) cnt[i] = 0;
    endtask

    task automatic random_counts();
        for (int i = 0; i < NW; i++)
            cnt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, TH + 2));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_outValid"}, 32'(outValid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bestValid"}, 32'(bestValid), 32'd0);
        chk({tag, "_bestWindowID"}, 32'(bestWindowID), 32'd0);
        chk({tag, "_bestCount"}, 32'(bestCount), 32'd0);
        chk({tag, "_numMatches"}, 32'(numMatches), 32'd0);
    endtask

    // ready_mode: 0 always ready, 1 random, 2 hold low for the first 4 valid cycles.
    // disturb: pulse queryDone with a different countBus in the middle of the scan.
    task automatic run_scan(input string tag, input int ready_mode, input bit disturb);
        int  exp_ids[$];
        int  max_cnt;
        int  exp_best_id;
        int  n;
        int  stalls;
        int  hold;
        int  ncand;
        bit  seen_done;
        bit  r;

        max_cnt = -1;
        for (int i = 0; i < NW; i++) begin
            if (cnt[i] >= TH) begin
                exp_ids.push_back(i);
                if (cnt[i] > max_cnt) max_cnt = cnt[i];
            end
        end
        ncand = exp_ids.size();
        exp_best_id = 0;
        for (int i = NW - 1; i >= 0; i--)
            if (cnt[i] >= TH && cnt[i] == max_cnt) exp_best_id = i;

        @(negedge clk);
        drive_bus_from_model();
        queryDone = 1'b1;
        outReady  = (ready_mode == 0);
        n = 0; stalls = 0; hold = 0; seen_done = 1'b0;
        while (!seen_done && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) queryDone = 1'b0;
            if (disturb && n == 4) begin
                for (int i = 0; i < NW; i++) countBus[i*CW +: CW] = CW'($urandom_range(0, 255));
                queryDone = 1'b1;
            end
            if (disturb && n == 5) queryDone = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (outValid) begin
                if (exp_ids.size() == 0) begin
                    chk({tag, "_extra_candidate"}, 32'(outWindowID), 32'hFFFF);
                end else begin
                    chk({tag, "_outWindowID"}, 32'(outWindowID), 32'(exp_ids[0]));
                    chk({tag, "_outCount"}, 32'(outCount), 32'(cnt[exp_ids[0]]));
                end
                case (ready_mode)
                    0: r = 1'b1;
                    1: r = 1'($urandom_range(0, 1));
                    default: begin
                        r = (hold >= 4);
                        hold++;
                    end
                endcase
                outReady = r;
                if (r) begin
                    if (exp_ids.size() != 0) void'(exp_ids.pop_front());
                end else begin
                    stalls++;
                end
            end else begin
                outReady = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (done) begin
                seen_done = 1'b1;
                chk({tag, "_done_latency"}, 32'(n), 32'(17 + ncand + stalls));
                chk({tag, "_missing_candidates"}, 32'(exp_ids.size()), 32'd0);
            end
        end
        if (!seen_done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_bestValid"}, 32'(bestValid), 32'(ncand > 0));
        chk({tag, "_bestWindowID"}, 32'(bestWindowID), 32'(exp_best_id));
        chk({tag, "_bestCount"}, 32'(bestCount), 32'((ncand > 0) ? max_cnt : 0));
        chk({tag, "_numMatches"}, 32'(numMatches), 32'(ncand));
        outReady = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        queryDone = 1'b0;
        outReady  = 1'b0;
        countBus  = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: no candidates, done 16 cycles after snapshot
        clear_counts();
        run_scan("t1_empty", 0, 1'b0);

        // 2: single match at window 14
        clear_counts();
        cnt[14] = 16;
        run_scan("t2_single", 0, 1'b0);

        // 3: backpressure, tie between 3 and 7
        clear_counts();
        cnt[0] = 5; cnt[3] = 9; cnt[7] = 9;
        run_scan("t3_backpressure", 2, 1'b0);

        // 4: threshold boundary
        clear_counts();
        cnt[2] = TH - 1; cnt[5] = TH;
        run_scan("t4_threshold", 0, 1'b0);

        // 5: second queryDone mid-scan is ignored
        random_counts();
        run_scan("t5_disturb", 1, 1'b1);

        // 6: reset while a candidate is pending
        clear_counts();
        cnt[3] = 10;
        @(negedge clk);
        drive_bus_from_model();
        queryDone = 1'b1;
        outReady  = 1'b0;
        @(negedge clk);
        queryDone = 1'b0;
        for (int i = 0; i < 20 && !outValid; i++) @(negedge clk);
        chk("t6_outValid_before", 32'(outValid), 32'd1);
        chk("t6_bestValid_before", 32'(bestValid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_idle_zero("t6_async");
        chk("t6_outWindowID", 32'(outWindowID), 32'd0);
        chk("t6_outCount", 32'(outCount), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done_after_reset", 32'(done), 32'd0);
        end
        random_counts();
        run_scan("t6_fresh", 0, 1'b0);

        // randomized scans
        for (int k = 0; k < 20; k++) begin
            random_counts();
            run_scan("rand", (k % 3 == 0) ? 0 : 1, (k % 5 == 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/query_result_handler.md
Name: query_result_handler

Overview:
- Read-side counterpart of the LSH input handler. After a query, the input handler presents per-window match counts on countBus.
- This block snapshots countBus and scans it one window per cycle. It streams every window whose count reaches THRESHOLD over a valid/ready interface.
- It also reports the single best-matching windowID, a match tally and a one-cycle done strobe to the top-level controller.

Parameters:
- NUM_WINDOWS, 16, number of window slots on countBus.
- ID_W, 4, windowID width; must satisfy 2^ID_W >= NUM_WINDOWS.
- COUNT_W, 8, width of each count entry.
- THRESHOLD, 4, minimum count for a window to be reported as a candidate.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- countBus  input  NUM_WINDOWS*COUNT_W  per-window counts; window i occupies bits [i*COUNT_W +: COUNT_W].
- queryDone  input  1  one-cycle pulse from the input handler: countBus is valid this cycle.
- outValid  output  1  candidate valid.
- outReady  input  1  downstream accepts candidate.
- outWindowID  output  ID_W  candidate windowID.
- outCount  output  COUNT_W  candidate count.
- busy  output  1  high from snapshot until done.
- done  output  1  one-cycle pulse: scan complete.
- bestValid  output  1  at least one candidate found in the last scan.
- bestWindowID  output  ID_W  highest-count candidate of the last scan.
- bestCount  output  COUNT_W  count of bestWindowID.
- numMatches  output  ID_W+1  number of candidates in the last scan.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs return to 0; the snapshot, index and match counters clear.
  - A scan in progress is abandoned; no done pulse is generated.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - queryDone=1 at edge k: snapshot countBus into internal registers, idx=0, clear best*/numMatches, busy=1 from edge k, go to SCAN.
- SCAN (one window per edge):
  - If snap[idx] >= THRESHOLD:
    - Load outWindowID=idx and outCount=snap[idx]; set outValid=1.
    - numMatches++.
    - Update best if snap[idx] > bestCount or bestValid==0, then set bestValid=1.
    - Go to EMIT.
  - Else, if idx==NUM_WINDOWS-1 go to DONE; otherwise idx++.
- EMIT:
  - outValid, outWindowID and outCount stay stable until outReady=1 is sampled at an edge.
  - At that edge outValid goes to 0. If idx==NUM_WINDOWS-1 go to DONE; else idx++ and return to SCAN.
  - outReady is ignored while outValid=0.
- DONE:
  - done=1 for exactly one cycle; busy=0 on the following edge; return to IDLE.
  - bestValid, bestWindowID, bestCount and numMatches hold until the next accepted queryDone or reset.
- Latency with no candidates (NUM_WINDOWS=16): queryDone at edge k, scan edges k+1..k+16, done high between edges k+16 and k+17.
- Each candidate adds 1 cycle plus the outReady wait.
- Tie rule: strict greater-than, so among equal counts the lowest windowID stays best.
- Counts are unsigned. A count of 0 is never reported when THRESHOLD >= 1. THRESHOLD=0 reports all windows.
- numMatches saturates at NUM_WINDOWS, which needs no extra logic given its width.
- queryDone while busy (SCAN/EMIT/DONE): ignored; the snapshot is not disturbed.
- countBus changes after the snapshot edge have no effect on the current scan.
- No candidates: bestValid=0, bestWindowID=0, bestCount=0, numMatches=0; done still pulses.
- Candidates are emitted in ascending windowID order; no candidate is dropped or duplicated under any outReady pattern.

Test Plan:
1. Reset, then pulse queryDone with all counts 0, outReady=1 -> no outValid; done exactly 16 cycles after the snapshot edge; bestValid=0, numMatches=0.
2. Single match: count[14]=16, others 0, outReady=1 -> one candidate (ID 14, count 16) for 1 cycle; bestWindowID=14, bestCount=16, numMatches=1; done pulses.
3. Backpressure: count[0]=5, count[3]=9, count[7]=9. Hold outReady=0 for 4 cycles, then 1 -> outValid/ID 0/count 5 held stable for 4 cycles. Emission order is 0, 3, 7; best=3 (tie with 7), bestCount=9, numMatches=3.
4. Threshold boundary: count[2]=3, count[5]=4 -> only ID 5 is emitted; bestWindowID=5.
5. Second queryDone pulse mid-scan with different countBus -> ignored; results match the first snapshot.
6. Assert reset during EMIT with outValid=1 -> outValid, busy, done and all best* outputs are 0 immediately (asynchronous); the next queryDone starts a fresh, correct scan.
